binary_to_bcd: RTL

Sequential double-dabble converter: accepts an unsigned binary word on a start strobe and produces its packed BCD equivalent after a fixed number of cycles. Sits directly upstream of the BCD adder datapath and turns binary operands (counters, register values) into 4-bit BCD digits the adder consumes. It is a multi-cycle, one-operation-at-a-time block with a start/busy/done handshake.

---
 rtl/binary_to_bcd_if.sv | 25 ++
 rtl/binary_to_bcd.sv | 129 ++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_if.sv
// Start/busy/done handshake bundle for the binary_to_bcd converter.
// The ovf signal exists only when BIN2BCD_OVF_EN is defined.
interface binary_to_bcd_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_OVF_EN
    logic                  ovf;

    modport master (output start, output bin_in,
                    input  busy, input done, input bcd_out, input ovf);
    modport slave  (input  start, input bin_in,
                    output busy, output done, output bcd_out, output ovf);
`else
    modport master (output start, output bin_in,
                    input  busy, input done, input bcd_out);
    modport slave  (input  start, input bin_in,
                    output busy, output done, output bcd_out);
`endif
endinterface

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble binary-to-packed-BCD converter, one operand at a time.
// Optional macro BIN2BCD_OVF_EN adds a sticky overflow flag for truncated results.
module binary_to_bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    binary_to_bcd_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state,   w_state_next;
    logic [BIN_W-1:0]   r_shift,   w_shift_next;
    logic [BCD_W-1:0]   r_scratch, w_scratch_next;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_next;
    logic               r_busy,    w_busy_next;
    logic               r_done,    w_done_next;
    logic [BCD_W-1:0]   r_bcd,     w_bcd_next;
`ifdef BIN2BCD_OVF_EN
    logic               r_sticky,  w_sticky_next;
    logic               r_ovf,     w_ovf_next;
`endif

    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+BIN_W-1:0] w_cat;

    // Per-digit add-3 correction; digits never carry into each other.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5)
                                      ? r_scratch[gi*4 +: 4] + 4'd3
                                      : r_scratch[gi*4 +: 4];
        end
    endgenerate

    assign w_cat = {w_adj, r_shift} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
`ifdef BIN2BCD_OVF_EN
            r_sticky  <= 1'b0;
            r_ovf     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_scratch <= w_scratch_next;
            r_cnt     <= w_cnt_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_bcd     <= w_bcd_next;
`ifdef BIN2BCD_OVF_EN
            r_sticky  <= w_sticky_next;
            r_ovf     <= w_ovf_next;
`endif
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_scratch_next = r_scratch;
        w_cnt_next     = r_cnt;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_bcd_next     = r_bcd;
`ifdef BIN2BCD_OVF_EN
        w_sticky_next  = r_sticky;
        w_ovf_next     = r_ovf;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_shift_next   = bus.bin_in;
                    w_scratch_next = '0;
                    w_cnt_next     = CNT_W'(BIN_W);
                    w_busy_next    = 1'b1;
`ifdef BIN2BCD_OVF_EN
                    w_sticky_next  = 1'b0;
`endif
                    w_state_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_scratch_next = w_cat[BIN_W +: BCD_W];
                w_shift_next   = w_cat[BIN_W-1:0];
                w_cnt_next     = r_cnt - CNT_W'(1);
`ifdef BIN2BCD_OVF_EN
                // Bit leaving the top digit means the value did not fit.
                w_sticky_next  = r_sticky | w_adj[BCD_W-1];
`endif
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_bcd_next   = r_scratch;
`ifdef BIN2BCD_OVF_EN
                w_ovf_next   = r_sticky;
`endif
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd;
`ifdef BIN2BCD_OVF_EN
    assign bus.ovf     = r_ovf;
`endif
endmodule
